regfile_multiport: RTL

//   Parametrised successor of the single-write/dual-read integer register bank.
//   - NUM_RD read ports and two write ports; depth and width are configurable.
//   - Entry 0 is hardwired to zero.
//   - After reset, a sweep FSM clears every entry, one per cycle.
//   - Sits between decode (read addresses) and writeback (two retire lanes) in the RISC-V core.

---
 rtl/regfile_pkg.sv | 41 ++++
 rtl/regfile_multiport_clear_fsm.sv | 62 ++++++
 rtl/regfile_multiport.sv | 112 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, limits and forwarding-select helper for the multiport register file
package regfile_pkg;

    // Sweep controller states: clearing storage after reset, then normal operation
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    // Upper bound on read ports supported by the bank
    localparam int RF_MAX_RD = 4;

    // Widest address the forwarding helper accepts; callers size-cast into it
    localparam int RF_MAX_AW = 16;

    // Forwarding source encodings returned by rf_fwd_sel
    localparam logic [1:0] RF_SRC_MEM   = 2'b00;
    localparam logic [1:0] RF_SRC_LANE0 = 2'b01;
    localparam logic [1:0] RF_SRC_LANE1 = 2'b10;

    // Picks where a same-cycle read should take its data from.
    // Lane 1 is the younger instruction so it overrides lane 0; writes to
    // entry 0 are dropped and therefore never forward.
    function automatic logic [1:0] rf_fwd_sel(
        input logic [RF_MAX_AW-1:0] addr,
        input logic                 we0,
        input logic [RF_MAX_AW-1:0] wa0,
        input logic                 we1,
        input logic [RF_MAX_AW-1:0] wa1
    );
        logic [1:0] sel;
        sel = RF_SRC_MEM;
        if (we1 && (wa1 != '0) && (wa1 == addr)) begin
            sel = RF_SRC_LANE1;
        end else if (we0 && (wa0 != '0) && (wa0 == addr)) begin
            sel = RF_SRC_LANE0;
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_multiport_clear_fsm.sv
// rtl/regfile_multiport_clear_fsm.sv - post-reset clear sweep controller: state, sweep pointer, ready
module regfile_multiport_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          ready
);

    // Last entry the sweep visits; entry 0 is never stored so the sweep starts at 1
    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] FIRST_ADDR = AW'(1);

    rf_state_t     state_q;
    rf_state_t     state_d;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // State and sweep pointer registers; reset always restarts the sweep at entry 1
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            ptr_q   <= FIRST_ADDR;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state and outputs: one entry cleared per cycle, RUN once the last entry is written
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clr_we   = 1'b0;
        clr_addr = ptr_q;
        ready    = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                clr_we = 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = RF_RUN;
                    ptr_d   = FIRST_ADDR;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            RF_RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_d = RF_CLEAR;
                ptr_d   = FIRST_ADDR;
            end
        endcase
    end

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - NUM_RD-read / 2-write register bank, entry 0 hardwired to zero; REGFILE_BYPASS_EN selects write-first reads
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    // Derived from DEPTH; left as a parameter only so it can size the ports
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic                    we0,
    input  logic [AW-1:0]           waddr0,
    input  logic [WIDTH-1:0]        wdata0,
    input  logic                    we1,
    input  logic [AW-1:0]           waddr1,
    input  logic [WIDTH-1:0]        wdata1,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data
);

    // Storage; index 0 is never written and every read of it is forced to zero
    logic [WIDTH-1:0] mem [DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_addr;

    regfile_multiport_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // Qualified lane enables: only in RUN, never to entry 0
    logic lane0_wr;
    logic lane1_wr;
    assign lane0_wr = ready && we0 && (waddr0 != '0);
    assign lane1_wr = ready && we1 && (waddr1 != '0);

    // Storage writes: sweep clear during CLEAR, otherwise both lanes with lane 1 applied last so it wins collisions
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else begin
                if (lane0_wr) begin
                    mem[waddr0] <= wdata0;
                end
                if (lane1_wr) begin
                    mem[waddr1] <= wdata1;
                end
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [AW-1:0]    ra;
            logic [WIDTH-1:0] rd_next;
            logic [WIDTH-1:0] rd_q;

            assign ra = rd_addr[k*AW +: AW];

`ifdef REGFILE_BYPASS_EN
            logic [1:0] src;
            assign src = rf_fwd_sel(RF_MAX_AW'(ra), lane0_wr, RF_MAX_AW'(waddr0),
                                    lane1_wr, RF_MAX_AW'(waddr1));

            // Write-first read: same-cycle write data overrides the stored value
            always_comb begin
                rd_next = mem[ra];
                case (src)
                    RF_SRC_LANE1: rd_next = wdata1;
                    RF_SRC_LANE0: rd_next = wdata0;
                    default:      rd_next = mem[ra];
                endcase
                if (ra == '0) begin
                    rd_next = '0;
                end
            end
`else
            // Read-first: the stored value before this edge's writes
            always_comb begin
                rd_next = mem[ra];
                if (ra == '0) begin
                    rd_next = '0;
                end
            end
`endif

            // Registered read port; held at zero through reset and the clear sweep
            always_ff @(posedge clk) begin
                if (rst || !ready) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_next;
                end
            end

            assign rd_data[k*WIDTH +: WIDTH] = rd_q;
        end
    endgenerate

endmodule
